// File: rtl/sec_tick_gen.sv
// Seconds time base: debounced run enable, TICK_HZ strobe and blink wave.
// Define SEC_TICK_FAST_SIM_EN to force DIV=10, DB_CYC=4 for short sims.
module sec_tick_gen #(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned TICK_HZ     = 1,
   parameter int unsigned DEBOUNCE_MS = 10
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_switch,
   output logic o_en,
   output logic o_en_rise,
   output logic o_tick,
   output logic o_blink
);

`ifdef SEC_TICK_FAST_SIM_EN
   localparam longint unsigned DIV    = 10;
   localparam longint unsigned DB_CYC = 4;
`else
   localparam longint unsigned DIV    = 64'(CLK_HZ) / 64'(TICK_HZ);
   localparam longint unsigned DB_CYC =
      (64'(CLK_HZ) / 64'd1000) * 64'(DEBOUNCE_MS);
`endif

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DB_W  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

   localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] PRE_HALF = DIV_W'(DIV / 2 - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);

   generate
      if (DIV < 4 || (DIV % 2) != 0 || DB_CYC < 1) begin : gBadParams
         $error("sec_tick_gen: DIV must be even and >= 4, DB_CYC >= 1");
      end
   endgenerate

   logic             sync1;
   logic             swSync;
   logic [DB_W-1:0]  dbCnt;
   logic [DIV_W-1:0] presc;
   logic             en;
   logic             enNext;
   logic             dbDone;
   logic             isLast;
   logic             isHalf;
   logic             enRise;
   logic             tick;
   logic             blink;

   assign dbDone = (swSync != en) && (dbCnt == DB_LAST);
   assign enNext = dbDone ? swSync : en;
   assign isLast = (presc == PRE_LAST);
   assign isHalf = (presc == PRE_HALF);

   // Tick and blink look at enNext so nothing fires on the edge o_en drops.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1  <= 1'b0;
         swSync <= 1'b0;
         dbCnt  <= '0;
         en     <= 1'b0;
         enRise <= 1'b0;
         presc  <= '0;
         tick   <= 1'b0;
         blink  <= 1'b0;
      end else begin
         sync1  <= i_switch;
         swSync <= sync1;
         if (swSync == en || dbDone) begin
            dbCnt <= '0;
         end else begin
            dbCnt <= dbCnt + DB_W'(1);
         end
         en     <= enNext;
         enRise <= dbDone && swSync;
         if (!en || isLast) begin
            presc <= '0;
         end else begin
            presc <= presc + DIV_W'(1);
         end
         tick <= en && enNext && isLast;
         if (!enNext) begin
            blink <= 1'b0;
         end else if (en && (isHalf || isLast)) begin
            blink <= ~blink;
         end
      end
   end

   assign o_en      = en;
   assign o_en_rise = enRise;
   assign o_tick    = tick;
   assign o_blink   = blink;

endmodule

// File: tb/tb_sec_tick_gen.sv
// Scoreboard bench for sec_tick_gen: DIV=10, DB_CYC=4 via parameters.
module tb_sec_tick_gen;

   localparam int DIV = 10;
   localparam int DB  = 4;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_switch = 1'b0;
   logic o_en;
   logic o_en_rise;
   logic o_tick;
   logic o_blink;

   int nCmp = 0;
   int nBad = 0;

   logic [3:0] expQ[$];

   // Reference: en follows the synced switch once DB samples in a row
   // disagree with it; outputs derive from cycles elapsed since the rise.
   bit mEn = 1'b0;
   int mK = 0;
   bit syncQ[$];
   bit winQ[$];

   sec_tick_gen #(
      .CLK_HZ(2000),
      .TICK_HZ(200),
      .DEBOUNCE_MS(2)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_switch(i_switch),
      .o_en(o_en),
      .o_en_rise(o_en_rise),
      .o_tick(o_tick),
      .o_blink(o_blink)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [3:0] modelStep(bit sw, bit rst);
      bit s;
      bit flip;
      bit rise;
      if (!rst) begin
         mEn = 1'b0;
         mK = 0;
         syncQ.delete();
         syncQ.push_back(1'b0);
         syncQ.push_back(1'b0);
         winQ.delete();
         return 4'b0000;
      end
      s = syncQ.pop_front();
      syncQ.push_back(sw);
      winQ.push_back(s);
      if (winQ.size() > DB) void'(winQ.pop_front());
      flip = (winQ.size() == DB);
      foreach (winQ[i]) if (winQ[i] == mEn) flip = 1'b0;
      rise = 1'b0;
      if (flip) begin
         mEn = !mEn;
         if (mEn) begin
            rise = 1'b1;
            mK = 0;
         end
      end else if (mEn) begin
         mK++;
      end
      return {mEn, rise,
              mEn && mK > 0 && (mK % DIV) == 0,
              mEn && (mK % DIV) >= DIV / 2};
   endfunction

   task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s t=%0t act{en,rise,tick,blink}=%b exp=%b",
                  name, $time, act, exp);
      end
   endtask

   task automatic cyc(bit sw);
      i_switch = sw;
      @(posedge i_clk);
      expQ.push_back(modelStep(sw, i_rst_n));
      #2;
   endtask

   task automatic pulseReset();
      i_rst_n = 1'b0;
      #1;
      chk("asyncRst", {o_en, o_en_rise, o_tick, o_blink}, 4'b0000);
   endtask

   initial begin : monitor
      logic [3:0] e;
      forever begin
         @(posedge i_clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("outputs", {o_en, o_en_rise, o_tick, o_blink}, e);
         end
      end
   end

   initial begin : driver
      bit v;
      int len;
      i_rst_n = 1'b0;
      i_switch = 1'b1;
      #2;
      repeat (4) cyc(1'b1);
      i_rst_n = 1'b1;
      repeat (45) cyc(1'b1);
      repeat (20) cyc(1'b0);
      repeat (3) cyc(1'b1);
      repeat (15) cyc(1'b0);
      for (int g = 0; g < 20 && !mEn; g++) cyc(1'b1);
      repeat (6) cyc(1'b1);
      repeat (12) cyc(1'b0);
      repeat (30) cyc(1'b1);
      repeat (7) cyc(1'b1);
      pulseReset();
      repeat (2) cyc(1'b1);
      i_rst_n = 1'b1;
      repeat (30) cyc(1'b1);
      for (int s = 0; s < 220; s++) begin
         v = bit'($urandom_range(0, 1));
         len = $urandom_range(1, 24);
         repeat (len) cyc(v);
         if ($urandom_range(0, 29) == 0) begin
            pulseReset();
            cyc(v);
            i_rst_n = 1'b1;
         end
      end
      repeat (3) cyc(i_switch);
      #20;
      nCmp++;
      if (expQ.size() != 0) begin
         nBad++;
         $display("FAIL drain left=%0d required=0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
